fft_r4_16p: RTL and testbench

- Streaming 16-point radix-4 decimation-in-frequency FFT.
- Accepts one complex sample per clock and assembles 16-sample frames.
- Emits each frame's spectrum as four columns of four complex bins (second-butterfly-stage outputs) over 4 consecutive cycles.
- Sits between a serial sample source and downstream spectral consumers; double-buffered so frames arrive back-to-back with no gaps.

---
 rtl/fft_r4_16p.sv | 156 +++++++++++++++
 tb/tb_fft_r4_16p.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fft_r4_16p.sv
// Streaming 16-point radix-4 DIF FFT: one complex Q16.16 sample per clock in,
// one column of four bins per clock out, double-buffered for gapless frames.
module fft_r4_16p (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] in_data_real,
    input  logic signed [31:0] in_data_im,
    output logic signed [31:0] bf2_output_0_real,
    output logic signed [31:0] bf2_output_0_im,
    output logic signed [31:0] bf2_output_1_real,
    output logic signed [31:0] bf2_output_1_im,
    output logic signed [31:0] bf2_output_2_real,
    output logic signed [31:0] bf2_output_2_im,
    output logic signed [31:0] bf2_output_3_real,
    output logic signed [31:0] bf2_output_3_im,
    output logic               out_valid,
    output logic [1:0]         out_col
);

    localparam int unsigned DW   = 32;
    localparam int unsigned TW   = 16;
    localparam int unsigned NPT  = 16;
    localparam int unsigned RAD  = 4;
    localparam int unsigned PW   = 49;
    localparam int unsigned FRAC = 14;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cpx_t;

    logic [3:0] cnt;
    logic       active;
    logic [1:0] col;
    cpx_t       smp;
    cpx_t       in_buf [NPT-1];
    cpx_t       work   [NPT];
    cpx_t       out_q  [RAD];
    cpx_t       y      [RAD];
    cpx_t       z      [RAD];
    cpx_t       xo     [RAD];

    assign smp.re = in_data_real;
    assign smp.im = in_data_im;

    function automatic cpx_t cadd(input cpx_t a, input cpx_t b);
        cpx_t r;
        r.re = a.re + b.re;
        r.im = a.im + b.im;
        return r;
    endfunction

    // Multiply by (-j)^k: exact swap/negate, no multiplier.
    function automatic cpx_t rot_nj(input cpx_t a, input logic [1:0] k);
        cpx_t r;
        case (k)
            2'd0:    begin r.re =  a.re; r.im =  a.im; end
            2'd1:    begin r.re =  a.im; r.im = -a.re; end
            2'd2:    begin r.re = -a.re; r.im = -a.im; end
            default: begin r.re = -a.im; r.im =  a.re; end
        endcase
        return r;
    endfunction

    // Full-width products, arithmetic shift by the Q1.14 fraction, then truncate.
    function automatic cpx_t cmul_q14(input cpx_t a,
                                      input logic signed [TW-1:0] wr,
                                      input logic signed [TW-1:0] wi);
        cpx_t r;
        logic signed [PW-1:0] pr;
        logic signed [PW-1:0] pi;
        pr = PW'(a.re) * PW'(wr) - PW'(a.im) * PW'(wi);
        pi = PW'(a.re) * PW'(wi) + PW'(a.im) * PW'(wr);
        r.re = DW'(pr >>> FRAC);
        r.im = DW'(pi >>> FRAC);
        return r;
    endfunction

    // Only exponents n*c for n,c in 0..3 are ever requested.
    function automatic cpx_t twiddle(input cpx_t a, input logic [3:0] k);
        cpx_t r;
        case (k)
            4'd1:    r = cmul_q14(a,  16'sd15137,  -16'sd6270);
            4'd2:    r = cmul_q14(a,  16'sd11585, -16'sd11585);
            4'd3:    r = cmul_q14(a,   16'sd6270, -16'sd15137);
            4'd4:    r = rot_nj(a, 2'd1);
            4'd6:    r = cmul_q14(a, -16'sd11585, -16'sd11585);
            4'd9:    r = cmul_q14(a, -16'sd15137,   16'sd6270);
            default: r = a;
        endcase
        return r;
    endfunction

    // Column c of the spectrum from the working buffer.
    always_comb begin
        for (int n = 0; n < RAD; n++) begin
            y[n]  = '0;
            z[n]  = '0;
            xo[n] = '0;
        end
        for (int n = 0; n < RAD; n++) begin
            for (int m = 0; m < RAD; m++) begin
                y[n] = cadd(y[n], rot_nj(work[4*m+n], 2'(m * int'(col))));
            end
            z[n] = twiddle(y[n], 4'(n * int'(col)));
        end
        for (int m = 0; m < RAD; m++) begin
            for (int n = 0; n < RAD; n++) begin
                xo[m] = cadd(xo[m], rot_nj(z[n], 2'(n * m)));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            active    <= 1'b0;
            col       <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            for (int i = 0; i < NPT - 1; i++) in_buf[i] <= '0;
            for (int i = 0; i < NPT; i++)     work[i]   <= '0;
            for (int i = 0; i < RAD; i++)     out_q[i]  <= '0;
        end else begin
            cnt <= cnt + 4'd1;
            if (cnt != 4'd15) in_buf[cnt] <= smp;

            // Last sample goes straight to the working buffer with the rest.
            if (cnt == 4'd15) begin
                for (int i = 0; i < NPT - 1; i++) work[i] <= in_buf[i];
                work[NPT-1] <= smp;
                active      <= 1'b1;
                col         <= '0;
            end else if (active) begin
                col <= col + 2'd1;
                if (col == 2'd3) active <= 1'b0;
            end

            out_valid <= active;
            if (active) begin
                for (int i = 0; i < RAD; i++) out_q[i] <= xo[i];
                out_col <= col;
            end
        end
    end

    assign bf2_output_0_real = out_q[0].re;
    assign bf2_output_0_im   = out_q[0].im;
    assign bf2_output_1_real = out_q[1].re;
    assign bf2_output_1_im   = out_q[1].im;
    assign bf2_output_2_real = out_q[2].re;
    assign bf2_output_2_im   = out_q[2].im;
    assign bf2_output_3_real = out_q[3].re;
    assign bf2_output_3_im   = out_q[3].im;

endmodule

// File: tb/tb_fft_r4_16p.sv
// Directed bench for fft_r4_16p: impulse, DC and ramp frames streamed
// back-to-back, plus asynchronous reset at start and mid-frame.
module tb_fft_r4_16p;

    localparam int K_IMP  = 0;
    localparam int K_DC   = 1;
    localparam int K_RAMP = 2;
    localparam int K_JUNK = 3;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic [31:0] o_re [4];
    logic [31:0] o_im [4];
    logic        out_valid;
    logic [1:0]  out_col;

    int vectors     = 0;
    int miscompares = 0;
    int next_col    = 4;
    int pend_kind   = 0;

    // Hand-derived bit-exact spectrum of x[n] = n + nj with the Q1.14 twiddles.
    int ramp_re [16] = '{  7864320, -3160064, -1790016, -1308928,
                          -1048576,  -874624,  -741440,  -628608,
                           -524288,  -419968,  -307136,  -173952,
                                 0,   260352,   741440,  2111488 };
    int ramp_im [16] = '{  7864320,  2111488,   741440,   260352,
                                 0,  -173952,  -307136,  -419968,
                           -524288,  -628608,  -741440,  -874624,
                          -1048576, -1308928, -1790016, -3160064 };

    always #5 clk = ~clk;

    fft_r4_16p dut (
        .clk               (clk),
        .reset             (reset),
        .in_data_real      (in_re),
        .in_data_im        (in_im),
        .bf2_output_0_real (o_re[0]),
        .bf2_output_0_im   (o_im[0]),
        .bf2_output_1_real (o_re[1]),
        .bf2_output_1_im   (o_im[1]),
        .bf2_output_2_real (o_re[2]),
        .bf2_output_2_im   (o_im[2]),
        .bf2_output_3_real (o_re[3]),
        .bf2_output_3_im   (o_im[3]),
        .out_valid         (out_valid),
        .out_col           (out_col)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] smp_re(input int kind, input int n);
        case (kind)
            K_IMP:   return (n == 0) ? ONE : 32'd0;
            K_DC:    return ONE;
            K_RAMP:  return 32'(n) << 16;
            default: return 32'h0005_0000 + 32'(n);
        endcase
    endfunction

    function automatic logic [31:0] smp_im(input int kind, input int n);
        case (kind)
            K_RAMP:  return 32'(n) << 16;
            K_JUNK:  return 32'h0003_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void exp_bin(input int kind, input int k,
                                    output logic [31:0] re, output logic [31:0] im);
        case (kind)
            K_IMP:   begin re = ONE; im = 32'd0; end
            K_DC:    begin re = (k == 0) ? 32'h0010_0000 : 32'd0; im = 32'd0; end
            K_RAMP:  begin re = 32'(ramp_re[k]); im = 32'(ramp_im[k]); end
            default: begin re = 32'hDEAD_BEEF; im = 32'hDEAD_BEEF; end
        endcase
    endfunction

    task automatic check_outputs();
        logic [31:0] er;
        logic [31:0] ei;
        if (next_col < 4) begin
            check($sformatf("kind%0d c%0d valid", pend_kind, next_col), 32'(out_valid), 32'd1);
            check($sformatf("kind%0d c%0d col", pend_kind, next_col), 32'(out_col), 32'(next_col));
            for (int m = 0; m < 4; m++) begin
                exp_bin(pend_kind, next_col + 4 * m, er, ei);
                check($sformatf("kind%0d X[%0d].re", pend_kind, next_col + 4 * m), o_re[m], er);
                check($sformatf("kind%0d X[%0d].im", pend_kind, next_col + 4 * m), o_im[m], ei);
            end
            next_col++;
        end else begin
            check("idle valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " col"}, 32'(out_col), 32'd0);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s out%0d.re", tag, m), o_re[m], 32'd0);
            check($sformatf("%s out%0d.im", tag, m), o_im[m], 32'd0);
        end
    endtask

    // Drive sample n of a frame, clock it in, then check what came out.
    task automatic step(input int kind, input int n);
        in_re = smp_re(kind, n);
        in_im = smp_im(kind, n);
        @(posedge clk);
        #1;
        check_outputs();
        if (n == 15) begin
            next_col  = 0;
            pend_kind = kind;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_re = '0;
        in_im = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        #2 reset = 1'b0;

        for (int n = 0; n < 16; n++) step(K_IMP, n);
        for (int n = 0; n < 16; n++) step(K_DC, n);
        for (int n = 0; n < 16; n++) step(K_RAMP, n);
        for (int n = 0; n < 7; n++)  step(K_JUNK, n);

        // Outputs still hold the last ramp column here, so zeros prove the async clear.
        #2 reset = 1'b1;
        #1 check_zero("mid reset");
        #2 reset = 1'b0;
        next_col = 4;

        for (int n = 0; n < 16; n++) step(K_IMP, n);
        for (int n = 0; n < 6; n++)  step(K_JUNK, n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
